regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have no parameters: data width 16, register address width 4, register count 16, all fixed.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_rd  input  4  requester A destination register.
REQ-006 a_data  input  16  requester A write data.
REQ-007 a_ready  output  1  requester A write accepted this cycle.
REQ-008 b_valid / b_rd / b_data / b_ready  input/input/input/output  1/4/16/1  requester B (load writeback), same meaning as A.
REQ-009 issue_set  input  1  an instruction with a destination register issued this cycle.
REQ-010 issue_rd  input  4  destination register of that issued instruction.
REQ-011 rs / rt  input  4 each  hazard-query register addresses.
REQ-012 rs_busy / rt_busy  output  1 each  queried register has an outstanding write.
REQ-013 RegWre  output  1  register-file write enable.
REQ-014 rd  output  4  register-file write address.
REQ-015 WriteData  output  16  register-file write data.
REQ-016 conflict_cnt  output  16  count of cycles where both requesters were valid.
REQ-017 idle  output  1  no busy bits set and RegWre low.

Function
REQ-018 Transfer SHALL occur on a rising edge where valid and ready are both high for a requester; at most one transfer per cycle.
REQ-019 a_ready SHALL be a_valid AND (NOT b_valid OR last_grant==B); b_ready SHALL be b_valid AND (NOT a_valid OR last_grant==A); both combinational.
REQ-020 A single valid requester SHALL be granted in the same cycle regardless of last_grant.
REQ-021 last_grant SHALL update to the granted requester on every transfer and hold otherwise.
REQ-022 On a transfer, RegWre/rd/WriteData SHALL be registered: next cycle RegWre=1, rd=granted rd, WriteData=granted data (latency exactly 1 cycle).
REQ-023 In a cycle with no transfer, the next cycle SHALL have RegWre=0; rd and WriteData SHALL hold their last values.
REQ-024 A transfer with rd==0 SHALL be accepted (ready high) and SHALL update last_grant, but the next cycle SHALL have RegWre=0.
REQ-025 Scoreboard busy[15:0]: issue_set with issue_rd!=0 SHALL set busy[issue_rd] at the edge; issue_rd==0 SHALL be ignored.
REQ-026 A transfer SHALL clear busy[granted rd] at the same edge it loads the output registers.
REQ-027 Same-edge set and clear of the same register SHALL leave busy set (new producer wins).
REQ-028 busy[0] SHALL be constant 0; rs_busy=busy[rs], rt_busy=busy[rt], combinational.
REQ-029 conflict_cnt SHALL increment on every edge where a_valid and b_valid are both high, saturating at 0xFFFF.
REQ-030 idle SHALL equal (busy==0) AND NOT RegWre.

Reset
REQ-031 RESET low SHALL immediately force RegWre=0, rd=0, WriteData=0, busy=0, conflict_cnt=0, last_grant=B (so A wins the first conflict).
REQ-032 Reset asserted mid-operation SHALL discard any in-flight write; the cycle after deassertion SHALL have RegWre=0.
REQ-033 Ready outputs SHALL remain combinational during reset; transfers SHALL have no effect while RESET is low.

Verification
REQ-034 After reset, a_valid=1 a_rd=3 a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle RegWre=1 rd=3 WriteData=0x1234; following cycle RegWre=0.
REQ-035 After reset, both valid (A rd=1 data=0xAAAA, B rd=2 data=0xBBBB) for 3 cycles -> grants A,B,A; outputs rd=1,2,1 on consecutive cycles; conflict_cnt=3.
REQ-036 issue_set with issue_rd=5, then rs=5 -> rs_busy=1; B writes rd=5 -> rs_busy=0 the cycle after the transfer edge; idle=1 once RegWre drops.
REQ-037 Same edge: issue_set rd=7 and A transfer rd=7 with busy[7] already set -> busy[7] remains 1; issue_rd=0 -> rs=0 query gives rs_busy=0.
REQ-038 A transfer rd=0 data=0xFFFF -> a_ready=1, next cycle RegWre=0, last_grant=A (verified by B winning next conflict).
REQ-039 RESET pulsed low in the cycle after a transfer -> RegWre falls to 0 asynchronously; busy and conflict_cnt read 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin tie-break,
// one-cycle registered write port, pending-write scoreboard and conflict counter.
module regfile_wb_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        a_valid,
    input  logic [3:0]  a_rd,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_rd,
    input  logic [15:0] b_data,
    output logic        b_ready,
    input  logic        issue_set,
    input  logic [3:0]  issue_rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        RegWre,
    output logic [3:0]  rd,
    output logic [15:0] WriteData,
    output logic [15:0] conflict_cnt,
    output logic        idle
);

    localparam int unsigned DataWidth = 16;
    localparam int unsigned AddrWidth = 4;
    localparam int unsigned RegCount  = 16;

    typedef enum logic {GrantA = 1'b0, GrantB = 1'b1} grant_t;

    grant_t                 lastGrant, lastGrantNext;
    logic [RegCount-1:0]    busy, busyNext;
    logic                   regWreNext;
    logic [AddrWidth-1:0]   rdNext, grantRd;
    logic [DataWidth-1:0]   writeDataNext, grantData;
    logic [DataWidth-1:0]   conflictNext;
    logic                   xfer;

    // Readies are combinational; the two are mutually exclusive by construction.
    assign a_ready = a_valid && (!b_valid || (lastGrant == GrantB));
    assign b_ready = b_valid && (!a_valid || (lastGrant == GrantA));
    assign xfer    = a_ready || b_ready;

    assign grantRd   = a_ready ? a_rd   : b_rd;
    assign grantData = a_ready ? a_data : b_data;

    assign rs_busy = busy[rs];
    assign rt_busy = busy[rt];
    assign idle    = (busy == '0) && !RegWre;

    // State registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lastGrant    <= GrantB;
            busy         <= '0;
            RegWre       <= 1'b0;
            rd           <= '0;
            WriteData    <= '0;
            conflict_cnt <= '0;
        end else begin
            lastGrant    <= lastGrantNext;
            busy         <= busyNext;
            RegWre       <= regWreNext;
            rd           <= rdNext;
            WriteData    <= writeDataNext;
            conflict_cnt <= conflictNext;
        end
    end

    // Next-state logic
    always_comb begin
        lastGrantNext = lastGrant;
        busyNext      = busy;
        regWreNext    = 1'b0;
        rdNext        = rd;
        writeDataNext = WriteData;
        conflictNext  = conflict_cnt;

        if (a_ready) begin
            lastGrantNext = GrantA;
        end else if (b_ready) begin
            lastGrantNext = GrantB;
        end

        // Writes to r0 are accepted but never reach the register file.
        if (xfer && (grantRd != AddrWidth'(0))) begin
            regWreNext    = 1'b1;
            rdNext        = grantRd;
            writeDataNext = grantData;
        end

        // Clear before set so a same-edge new producer keeps the bit set.
        if (xfer) begin
            busyNext[grantRd] = 1'b0;
        end
        if (issue_set && (issue_rd != AddrWidth'(0))) begin
            busyNext[issue_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;

        if (a_valid && b_valid && (conflict_cnt != {DataWidth{1'b1}})) begin
            conflictNext = conflict_cnt + DataWidth'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model with a queue of
// expected write-port results, directed scenarios plus a random phase.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        a_valid, b_valid, issue_set;
    logic [3:0]  a_rd, b_rd, issue_rd, rs, rt;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, rs_busy, rt_busy, RegWre, idle;
    logic [3:0]  rd;
    logic [15:0] WriteData, conflict_cnt;

    regfile_wb_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_set(issue_set), .issue_rd(issue_rd), .rs(rs), .rt(rt),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .RegWre(RegWre), .rd(rd),
        .WriteData(WriteData), .conflict_cnt(conflict_cnt), .idle(idle)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wre;
        logic [3:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t         expQ[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic        mLastA;
    logic [15:0] mBusy;
    logic [15:0] mCnt;
    logic [3:0]  mRd;
    logic [15:0] mData;
    logic        mWre;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic idleInputs();
        a_valid = 0; b_valid = 0; issue_set = 0;
        a_rd = 0; b_rd = 0; issue_rd = 0; a_data = 0; b_data = 0;
    endtask

    task automatic modelReset();
        mLastA = 0; mBusy = 0; mCnt = 0; mRd = 0; mData = 0; mWre = 0;
        expQ.delete();
    endtask

    task automatic doReset();
        RESET = 1'b0;
        #1;
        modelReset();
        checkVal("rst_RegWre", 32'(RegWre), 32'd0);
        checkVal("rst_rd", 32'(rd), 32'd0);
        checkVal("rst_WriteData", 32'(WriteData), 32'd0);
        checkVal("rst_conflict", 32'(conflict_cnt), 32'd0);
        checkVal("rst_busy_rs", 32'(rs_busy), 32'd0);
        checkVal("rst_idle", 32'(idle), 32'd1);
        #2 RESET = 1'b1;
        @(negedge CLK);
    endtask

    // One clock: inputs already driven at the negedge.
    task automatic step(input string tag);
        logic ar, br, x;
        logic [3:0] grd;
        logic [15:0] gdat;
        wr_t e, got;
        #1;
        ar = a_valid && (!b_valid || !mLastA);
        br = b_valid && (!a_valid || mLastA);
        checkVal({tag, "_a_ready"}, 32'(a_ready), 32'(ar));
        checkVal({tag, "_b_ready"}, 32'(b_ready), 32'(br));
        checkVal({tag, "_rs_busy"}, 32'(rs_busy), 32'(mBusy[rs]));
        checkVal({tag, "_rt_busy"}, 32'(rt_busy), 32'(mBusy[rt]));
        x    = ar || br;
        grd  = ar ? a_rd : b_rd;
        gdat = ar ? a_data : b_data;
        if (x && grd != 4'd0) begin
            mWre = 1; mRd = grd; mData = gdat;
        end else begin
            mWre = 0;
        end
        e.wre = mWre; e.rd = mRd; e.data = mData;
        expQ.push_back(e);
        if (ar) mLastA = 1;
        else if (br) mLastA = 0;
        if (x) mBusy[grd] = 1'b0;
        if (issue_set && issue_rd != 4'd0) mBusy[issue_rd] = 1'b1;
        if (a_valid && b_valid && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        @(posedge CLK);
        #1;
        got = expQ.pop_front();
        checkVal({tag, "_RegWre"}, 32'(RegWre), 32'(got.wre));
        checkVal({tag, "_rd"}, 32'(rd), 32'(got.rd));
        checkVal({tag, "_WriteData"}, 32'(WriteData), 32'(got.data));
        checkVal({tag, "_conflict"}, 32'(conflict_cnt), 32'(mCnt));
        checkVal({tag, "_idle"}, 32'(idle), 32'((mBusy == 16'd0) && !got.wre));
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        idleInputs();
        rs = 0; rt = 0;
        modelReset();
        @(negedge CLK);
        doReset();

        // Single A write, then idle cycle.
        a_valid = 1; a_rd = 3; a_data = 16'h1234;
        step("single");
        checkVal("single_rd3", 32'(rd), 32'd3);
        idleInputs();
        step("single_after");
        checkVal("single_drop", 32'(RegWre), 32'd0);

        // Conflict round-robin from reset: A, B, A.
        doReset();
        a_valid = 1; a_rd = 1; a_data = 16'hAAAA;
        b_valid = 1; b_rd = 2; b_data = 16'hBBBB;
        step("rr0"); checkVal("rr0_rd", 32'(rd), 32'd1);
        step("rr1"); checkVal("rr1_rd", 32'(rd), 32'd2);
        step("rr2"); checkVal("rr2_rd", 32'(rd), 32'd1);
        checkVal("rr_cnt3", 32'(conflict_cnt), 32'd3);
        idleInputs();
        step("rr_idle");

        // Scoreboard set by issue, cleared by B writeback.
        issue_set = 1; issue_rd = 5; rs = 5;
        step("sb_issue");
        idleInputs();
        #1 checkVal("sb_rs_busy", 32'(rs_busy), 32'd1);
        b_valid = 1; b_rd = 5; b_data = 16'h0055;
        step("sb_wb");
        checkVal("sb_rs_clear", 32'(rs_busy), 32'd0);
        idleInputs();
        step("sb_drop");
        checkVal("sb_idle", 32'(idle), 32'd1);

        // Same-edge set and clear of r7: new producer wins; r0 issue ignored.
        issue_set = 1; issue_rd = 7; rs = 7;
        step("same_pre");
        a_valid = 1; a_rd = 7; a_data = 16'h0777;
        issue_set = 1; issue_rd = 7;
        step("same_edge");
        checkVal("same_busy7", 32'(rs_busy), 32'd1);
        idleInputs();
        issue_set = 1; issue_rd = 0; rs = 0;
        step("r0_issue");
        checkVal("r0_rs_busy", 32'(rs_busy), 32'd0);

        // Write to r0 is accepted without RegWre and still moves last_grant.
        doReset();
        a_valid = 1; a_rd = 0; a_data = 16'hFFFF;
        step("rd0");
        checkVal("rd0_nowre", 32'(RegWre), 32'd0);
        a_valid = 1; a_rd = 1; a_data = 16'h0101;
        b_valid = 1; b_rd = 2; b_data = 16'h0202;
        #1 checkVal("rd0_b_wins", 32'(b_ready), 32'd1);
        step("rd0_conf");
        checkVal("rd0_conf_rd", 32'(rd), 32'd2);
        idleInputs();

        // Reset pulsed in the cycle after a transfer.
        issue_set = 1; issue_rd = 9; rs = 9;
        a_valid = 1; a_rd = 4; a_data = 16'h4444;
        b_valid = 1; b_rd = 6; b_data = 16'h6666;
        step("pre_rst");
        checkVal("pre_rst_wre", 32'(RegWre), 32'd1);
        idleInputs();
        doReset();
        step("post_rst");

        // Random phase.
        for (int i = 0; i < 300; i++) begin
            a_valid = 1'($urandom); b_valid = 1'($urandom);
            a_rd = 4'($urandom); b_rd = 4'($urandom);
            a_data = 16'($urandom); b_data = 16'($urandom);
            issue_set = 1'($urandom); issue_rd = 4'($urandom);
            rs = 4'($urandom); rt = 4'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
